// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester, clear and RAM-side signals of the RAM arbiter
interface ram_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          AReq;
   logic          AWe;
   logic [AW-1:0] AAddr;
   logic [DW-1:0] AWdata;
   logic          AAck;
   logic [DW-1:0] ARdata;

   logic          BReq;
   logic          BWe;
   logic [AW-1:0] BAddr;
   logic [DW-1:0] BWdata;
   logic          BAck;
   logic [DW-1:0] BRdata;

   logic          ClrReq;
   logic          Busy;

   logic [AW-1:0] RamAddr;
   logic [DW-1:0] RamDin;
   logic          RamStore;
   logic          RamClear;
   logic [DW-1:0] RamData;

   modport slave (
      input  AReq, AWe, AAddr, AWdata,
      input  BReq, BWe, BAddr, BWdata,
      input  ClrReq, RamData,
      output AAck, ARdata, BAck, BRdata, Busy,
      output RamAddr, RamDin, RamStore, RamClear
   );

   modport master (
      output AReq, AWe, AAddr, AWdata,
      output BReq, BWe, BAddr, BWdata,
      output ClrReq, RamData,
      input  AAck, ARdata, BAck, BRdata, Busy,
      input  RamAddr, RamDin, RamStore, RamClear
   );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port sequencer for a single-port RAM with clear scheduling
module ram_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SERVE, DONE, CLEAR} state_t;

   state_t        state, state_nxt;
   logic          last;      // 1 = port B was granted last
   logic          win_b;
   logic          clr_pend;
   logic          a_ack, b_ack;
   logic [DW-1:0] a_rdata, b_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_store, ram_clear;
   logic          clr_now, grant_a, grant_b;

   always_comb begin
      clr_now   = bus.ClrReq | clr_pend;
      grant_a   = bus.AReq & (~bus.BReq | last);
      grant_b   = bus.BReq & (~bus.AReq | ~last);
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clr_now)
               state_nxt = CLEAR;
            else if (grant_a | grant_b)
               state_nxt = SERVE;
         end
         SERVE:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         CLEAR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last      <= 1'b1;
         win_b     <= 1'b0;
         clr_pend  <= 1'b0;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         ram_addr  <= '0;
         ram_din   <= '0;
         ram_store <= 1'b0;
         ram_clear <= 1'b0;
      end else begin
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         ram_clear <= 1'b0;
         // Pulses arriving during CLEAR are absorbed by the clear in progress.
         if (state == CLEAR)
            clr_pend <= 1'b0;
         else if (bus.ClrReq)
            clr_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (clr_now) begin
                  ram_clear <= 1'b1;
                  ram_store <= 1'b0;
               end else if (grant_a) begin
                  ram_addr  <= bus.AAddr;
                  ram_din   <= bus.AWdata;
                  ram_store <= bus.AWe;
                  win_b     <= 1'b0;
                  last      <= 1'b0;
               end else if (grant_b) begin
                  ram_addr  <= bus.BAddr;
                  ram_din   <= bus.BWdata;
                  ram_store <= bus.BWe;
                  win_b     <= 1'b1;
                  last      <= 1'b1;
               end
            end
            SERVE: begin
               if (!ram_store) begin
                  if (win_b)
                     b_rdata <= bus.RamData;
                  else
                     a_rdata <= bus.RamData;
               end
               ram_store <= 1'b0;
               if (win_b)
                  b_ack <= 1'b1;
               else
                  a_ack <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.Busy     = (state != IDLE) | clr_pend;
   assign bus.AAck     = a_ack;
   assign bus.BAck     = b_ack;
   assign bus.ARdata   = a_rdata;
   assign bus.BRdata   = b_rdata;
   assign bus.RamAddr  = ram_addr;
   assign bus.RamDin   = ram_din;
   assign bus.RamStore = ram_store;
   assign bus.RamClear = ram_clear;
endmodule
